// File: rtl/demux_4_stream.sv
// Registered 1-to-4 stream demultiplexer: each beat is routed by iSel into one of
// four independent 2-entry lane FIFOs, so a stalled consumer only blocks its own lane.
module demux_4_stream #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic                  iValid,
  input  logic [1:0]            iSel,
  output logic                  oReady,
  output logic [DATA_WIDTH-1:0] oData0,
  output logic [DATA_WIDTH-1:0] oData1,
  output logic [DATA_WIDTH-1:0] oData2,
  output logic [DATA_WIDTH-1:0] oData3,
  output logic                  oValid0,
  output logic                  oValid1,
  output logic                  oValid2,
  output logic                  oValid3,
  input  logic                  iReady0,
  input  logic                  iReady1,
  input  logic                  iReady2,
  input  logic                  iReady3,
  output logic [3:0]            oLaneFull
);

  logic [DATA_WIDTH-1:0] mem [4][2];
  logic [1:0]            cnt [4];
  logic [3:0]            wr_ptr;
  logic [3:0]            rd_ptr;
  logic [3:0]            lane_valid;
  logic [3:0]            lane_full;
  logic [3:0]            lane_ready;
  logic [3:0]            push;
  logic [3:0]            pop;

  assign lane_ready = {iReady3, iReady2, iReady1, iReady0};

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_valid[k] = (cnt[k] != 2'd0);
      lane_full[k]  = (cnt[k] == 2'd2);
    end
  end

  // oReady looks only at registered counts, so a pop cannot free space in the same cycle.
  assign oReady = ~lane_full[iSel];

  always_comb begin
    push = 4'b0000;
    if (iValid && oReady) begin
      push[iSel] = 1'b1;
    end
  end

  assign pop = lane_valid & lane_ready;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      for (int k = 0; k < 4; k++) begin
        cnt[k]    <= 2'd0;
        mem[k][0] <= '0;
        mem[k][1] <= '0;
      end
      wr_ptr <= 4'b0000;
      rd_ptr <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= iData;
          wr_ptr[k]         <= ~wr_ptr[k];
        end
        if (pop[k]) begin
          rd_ptr[k] <= ~rd_ptr[k];
        end
        cnt[k] <= cnt[k] + {1'b0, push[k]} - {1'b0, pop[k]};
      end
    end
  end

  // Head entries stay visible after a pop; consumers qualify with oValidk.
  assign oData0 = mem[0][rd_ptr[0]];
  assign oData1 = mem[1][rd_ptr[1]];
  assign oData2 = mem[2][rd_ptr[2]];
  assign oData3 = mem[3][rd_ptr[3]];

  assign oValid0   = lane_valid[0];
  assign oValid1   = lane_valid[1];
  assign oValid2   = lane_valid[2];
  assign oValid3   = lane_valid[3];
  assign oLaneFull = lane_full;

endmodule

// File: tb/tb_demux_4_stream.sv
// Scoreboard bench for demux_4_stream: per-lane expected-data queues are filled on
// accepted pushes and drained by an independent monitor on consumer handshakes.
module tb_demux_4_stream;

  logic        iClk = 1'b0;
  logic        iReset = 1'b1;
  logic [31:0] iData = '0;
  logic        iValid = 1'b0;
  logic [1:0]  iSel = 2'd0;
  logic        oReady;
  logic [31:0] oData0, oData1, oData2, oData3;
  logic        oValid0, oValid1, oValid2, oValid3;
  logic        iReady0 = 1'b0, iReady1 = 1'b0, iReady2 = 1'b0, iReady3 = 1'b0;
  logic [3:0]  oLaneFull;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] sb [4][$];

  demux_4_stream #(.DATA_WIDTH(32)) dut (
    .iClk(iClk), .iReset(iReset), .iData(iData), .iValid(iValid), .iSel(iSel),
    .oReady(oReady),
    .oData0(oData0), .oData1(oData1), .oData2(oData2), .oData3(oData3),
    .oValid0(oValid0), .oValid1(oValid1), .oValid2(oValid2), .oValid3(oValid3),
    .iReady0(iReady0), .iReady1(iReady1), .iReady2(iReady2), .iReady3(iReady3),
    .oLaneFull(oLaneFull)
  );

  always #5 iClk = ~iClk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_data(input int k);
    case (k)
      0: return oData0;
      1: return oData1;
      2: return oData2;
      default: return oData3;
    endcase
  endfunction

  function automatic logic [3:0] model_full();
    logic [3:0] f;
    for (int k = 0; k < 4; k++) f[k] = (sb[k].size() == 2);
    return f;
  endfunction

  // Monitor: compares lane outputs with queue heads, then retires beats the consumer takes.
  initial begin
    logic [3:0] pend;
    logic [3:0] vld;
    logic [3:0] rdy;
    forever begin
      @(negedge iClk);
      #2;
      pend = 4'b0000;
      if (!iReset) begin
        vld = {oValid3, oValid2, oValid1, oValid0};
        rdy = {iReady3, iReady2, iReady1, iReady0};
        for (int k = 0; k < 4; k++) begin
          checkOutput($sformatf("oValid%0d", k), {31'd0, vld[k]}, {31'd0, sb[k].size() != 0});
          if (sb[k].size() != 0) begin
            checkOutput($sformatf("oData%0d", k), lane_data(k), sb[k][0]);
            pend[k] = rdy[k];
          end
        end
        checkOutput("oLaneFull", {28'd0, oLaneFull}, {28'd0, model_full()});
      end
      @(posedge iClk);
      #1;
      if (!iReset) begin
        for (int k = 0; k < 4; k++) begin
          if (pend[k]) void'(sb[k].pop_front());
        end
      end
    end
  end

  // Drives one cycle of stimulus; the model decides acceptance from queue occupancy.
  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [31:0] d,
                               input logic [3:0] r, output logic acc);
    @(negedge iClk);
    iValid = v; iSel = s; iData = d;
    {iReady3, iReady2, iReady1, iReady0} = r;
    #1;
    checkOutput("oReady", {31'd0, oReady}, {31'd0, sb[s].size() < 2});
    acc = v && (sb[s].size() < 2);
    @(posedge iClk);
    #1;
    if (acc && !iReset) sb[s].push_back(d);
  endtask

  task automatic sendUntilAccepted(input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) applyStimulus(1'b1, s, d, r, acc);
    checkOutput("accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle(input int n, input logic [3:0] r);
    logic acc;
    for (int t = 0; t < n; t++) applyStimulus(1'b0, 2'd0, 32'd0, r, acc);
  endtask

  // Asserts reset between edges and expects every lane to clear without a clock.
  task automatic doReset();
    @(negedge iClk);
    #3;
    iReset = 1'b1;
    #1;
    checkOutput("rst_valid", {28'd0, oValid3, oValid2, oValid1, oValid0}, 32'd0);
    checkOutput("rst_full", {28'd0, oLaneFull}, 32'd0);
    checkOutput("rst_ready", {31'd0, oReady}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rst_data%0d", k), lane_data(k), 32'd0);
      sb[k].delete();
    end
    @(posedge iClk);
    #3;
    iReset = 1'b0;
  endtask

  initial begin
    logic acc;
    logic [3:0] r;
    #12;
    doReset();
    idle(2, 4'b0000);

    applyStimulus(1'b1, 2'd2, 32'hA5A5_0001, 4'b0100, acc);
    idle(3, 4'b0100);

    applyStimulus(1'b1, 2'd1, 32'h11, 4'b0000, acc);
    applyStimulus(1'b1, 2'd1, 32'h22, 4'b0000, acc);
    applyStimulus(1'b1, 2'd1, 32'h33, 4'b0000, acc);
    applyStimulus(1'b1, 2'd1, 32'h33, 4'b0000, acc);
    checkOutput("lane1_stall", {31'd0, acc}, 32'd0);
    sendUntilAccepted(2'd1, 32'h33, 4'b0010);
    idle(4, 4'b0010);

    sendUntilAccepted(2'd0, 32'h100, 4'b0000);
    sendUntilAccepted(2'd0, 32'h101, 4'b0000);
    for (int t = 0; t < 10; t++) begin
      applyStimulus(1'b1, (t % 2 == 0) ? 2'd0 : 2'd3, 32'h300 + t, 4'b1000, acc);
    end
    idle(4, 4'b1111);

    sendUntilAccepted(2'd2, 32'hB0, 4'b0000);
    applyStimulus(1'b1, 2'd2, 32'hB1, 4'b0100, acc);
    idle(2, 4'b0000);
    idle(3, 4'b1111);

    sendUntilAccepted(2'd0, 32'hC0, 4'b0000);
    sendUntilAccepted(2'd3, 32'hC3, 4'b0000);
    sendUntilAccepted(2'd3, 32'hC4, 4'b0000);
    doReset();
    idle(3, 4'b1111);

    for (int t = 0; t < 900; t++) begin
      r = (t < 300) ? 4'($urandom) : (t < 600) ? 4'($urandom & $urandom) : 4'($urandom | $urandom);
      applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, r, acc);
    end
    idle(6, 4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
